// File: rtl/auth_response_gate_pkg.sv
// Shared constants for the authentication response gate: FSM encoding and
// default timing/lockout parameters reused by the comparator and integration.
package auth_response_gate_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    localparam int RESP_LAT_DEF    = 16;
    localparam int MAX_FAILS_DEF   = 3;
    localparam int FAIL_W_DEF      = 4;
    localparam int LOCK_CYCLES_DEF = 1024;
    localparam int LOCK_W_DEF      = 16;

endpackage : auth_response_gate_pkg

// File: rtl/auth_lock_timer.sv
// Loadable down-counter used to time the lockout window. expire is high while
// enabled on the last counted cycle (count == 1).
module auth_lock_timer
    import auth_response_gate_pkg::*;
#(
    parameter int W = LOCK_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic         expire
);

    localparam logic [W-1:0] ONE_V = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load has priority, otherwise decrement while enabled and non-zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (enable && (count_q != {W{1'b0}})) begin
            count_d = count_q - ONE_V;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && (count_q == ONE_V);

endmodule : auth_lock_timer

// File: rtl/auth_response_gate.sv
// Fixed-latency grant/deny gate behind the password comparator. The response
// always appears RESP_LAT cycles after acceptance so that result timing never
// leaks; consecutive failures lead to a timed lockout.
module auth_response_gate
    import auth_response_gate_pkg::*;
#(
    parameter int RESP_LAT    = RESP_LAT_DEF,
    parameter int MAX_FAILS   = MAX_FAILS_DEF,
    parameter int FAIL_W      = FAIL_W_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter int LOCK_W      = LOCK_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              attempt_start,
    output logic              attempt_ready,
    output logic              cmp_clear,
    input  logic              result_valid,
    input  logic              result_pass,
    output logic              resp_valid,
    output logic              grant,
    output logic              deny,
    output logic              locked,
    output logic [FAIL_W-1:0] fail_count
);

    localparam logic [7:0]        RESP_LAST_V = 8'(RESP_LAT - 1);
    localparam logic [FAIL_W-1:0] MAX_FAILS_V = FAIL_W'(MAX_FAILS);
    localparam logic [FAIL_W-1:0] FAIL_SAT_V  = {FAIL_W{1'b1}};
    localparam logic [FAIL_W-1:0] FAIL_ONE_V  = {{(FAIL_W-1){1'b0}}, 1'b1};
    localparam logic [LOCK_W-1:0] LOCK_LOAD_V = LOCK_W'(LOCK_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [7:0]        timer_q, timer_d;
    logic              got_result_q, got_result_d;
    logic              pass_latch_q, pass_latch_d;
    logic              cmp_clear_q, cmp_clear_d;
    logic              resp_valid_q, resp_valid_d;
    logic              grant_q, grant_d;
    logic              deny_q, deny_d;
    logic              locked_q, locked_d;
    logic [FAIL_W-1:0] fail_count_q, fail_count_d;

    logic              verdict_s;
    logic [FAIL_W-1:0] fail_inc_s;
    logic              lock_load_s;
    logic              lock_expire_s;

    auth_lock_timer #(.W(LOCK_W)) u_lock_timer (
        .clk      (clk),
        .rst_n    (reset_n),
        .load     (lock_load_s),
        .load_val (LOCK_LOAD_V),
        .enable   (state_q == ST_LOCKED),
        .expire   (lock_expire_s)
    );

    // Verdict including a strobe landing on the last WAIT cycle, and the saturating failure increment.
    always_comb begin
        verdict_s  = (got_result_q | result_valid) & (got_result_q ? pass_latch_q : result_pass);
        fail_inc_s = (fail_count_q == FAIL_SAT_V) ? fail_count_q : (fail_count_q + FAIL_ONE_V);
    end

    // FSM next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        got_result_d = got_result_q;
        pass_latch_d = pass_latch_q;
        cmp_clear_d  = 1'b0;
        resp_valid_d = 1'b0;
        grant_d      = 1'b0;
        deny_d       = 1'b0;
        locked_d     = locked_q;
        fail_count_d = fail_count_q;
        lock_load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (attempt_start) begin
                    state_d      = ST_WAIT;
                    timer_d      = 8'd0;
                    got_result_d = 1'b0;
                    pass_latch_d = 1'b0;
                    cmp_clear_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 8'd1;
                // Only the first strobe of the window is kept.
                if (result_valid && !got_result_q) begin
                    got_result_d = 1'b1;
                    pass_latch_d = result_pass;
                end else begin
                    got_result_d = got_result_q;
                end
                if (timer_q == RESP_LAST_V) begin
                    state_d      = ST_RESPOND;
                    resp_valid_d = 1'b1;
                    grant_d      = verdict_s;
                    deny_d       = !verdict_s;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                if (grant_q) begin
                    fail_count_d = {FAIL_W{1'b0}};
                    state_d      = ST_IDLE;
                end else begin
                    fail_count_d = fail_inc_s;
                    if (fail_inc_s >= MAX_FAILS_V) begin
                        state_d     = ST_LOCKED;
                        locked_d    = 1'b1;
                        lock_load_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOCKED: begin
                if (lock_expire_s) begin
                    state_d      = ST_IDLE;
                    locked_d     = 1'b0;
                    fail_count_d = {FAIL_W{1'b0}};
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                locked_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= 8'd0;
            got_result_q <= 1'b0;
            pass_latch_q <= 1'b0;
            cmp_clear_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            grant_q      <= 1'b0;
            deny_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_count_q <= {FAIL_W{1'b0}};
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            got_result_q <= got_result_d;
            pass_latch_q <= pass_latch_d;
            cmp_clear_q  <= cmp_clear_d;
            resp_valid_q <= resp_valid_d;
            grant_q      <= grant_d;
            deny_q       <= deny_d;
            locked_q     <= locked_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign attempt_ready = (state_q == ST_IDLE);
    assign cmp_clear     = cmp_clear_q;
    assign resp_valid    = resp_valid_q;
    assign grant         = grant_q;
    assign deny          = deny_q;
    assign locked        = locked_q;
    assign fail_count    = fail_count_q;

endmodule : auth_response_gate

// File: tb/tb_auth_response_gate.sv
// Self-checking bench for auth_response_gate: an edge-indexed reference model
// (acceptance edge + fixed offsets) checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_auth_response_gate;

    localparam int R  = 16;
    localparam int MF = 3;
    localparam int L  = 1024;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       attempt_start = 1'b0;
    logic       attempt_ready;
    logic       cmp_clear;
    logic       result_valid = 1'b0;
    logic       result_pass = 1'b0;
    logic       resp_valid;
    logic       grant;
    logic       deny;
    logic       locked;
    logic [3:0] fail_count;

    int n_checks = 0;
    int n_pass   = 0;

    auth_response_gate dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .attempt_start (attempt_start),
        .attempt_ready (attempt_ready),
        .cmp_clear     (cmp_clear),
        .result_valid  (result_valid),
        .result_pass   (result_pass),
        .resp_valid    (resp_valid),
        .grant         (grant),
        .deny          (deny),
        .locked        (locked),
        .fail_count    (fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // ---------------- reference model: everything keyed on edge numbers ----
    int  cyc = 0;
    int  acc = -1;          // edge at which the current attempt was accepted
    bit  have = 1'b0;       // a result was seen inside the window
    bit  pv = 1'b0;         // verdict of that first result
    int  fc = 0;
    int  lock_lo = -1, lock_hi = -2;
    int  fc_clear_at = -1;
    int  ready_from = 0;    // first edge at which attempt_start is accepted

    always @(posedge clk) begin
        bit st, rv, rp, rn, acc_now, ok;
        int e_ready, e_clr, e_resp, e_grant, e_deny, e_lock, e_fc;
        st = attempt_start; rv = result_valid; rp = result_pass; rn = reset_n;
        cyc++;
        acc_now = 1'b0;
        if (!rn) begin
            acc = -1; have = 1'b0; pv = 1'b0; fc = 0;
            lock_lo = -1; lock_hi = -2; fc_clear_at = -1; ready_from = 0;
        end else begin
            if (acc >= 0 && cyc >= acc + 1 && cyc <= acc + R && rv && !have) begin
                have = 1'b1; pv = rp;
            end
            if (cyc == fc_clear_at) fc = 0;
            if (acc >= 0 && cyc == acc + R + 1) begin
                if (have && pv) fc = 0;
                else begin
                    fc = (fc == 15) ? 15 : fc + 1;
                    if (fc >= MF) begin
                        lock_lo = cyc; lock_hi = cyc + L - 1;
                        fc_clear_at = cyc + L; ready_from = cyc + L + 1;
                    end
                end
            end
            if (cyc >= ready_from && st) begin
                acc_now = 1'b1; acc = cyc; have = 1'b0; ready_from = cyc + R + 2;
            end
        end
        ok      = have && pv;
        e_resp  = (rn && acc >= 0 && cyc == acc + R) ? 1 : 0;
        e_grant = (e_resp == 1 && ok) ? 1 : 0;
        e_deny  = (e_resp == 1 && !ok) ? 1 : 0;
        e_clr   = acc_now ? 1 : 0;
        e_lock  = (rn && cyc >= lock_lo && cyc <= lock_hi) ? 1 : 0;
        e_ready = (!rn || cyc >= ready_from - 1) ? 1 : 0;
        e_fc    = fc;
        #1;
        chk("cyc.attempt_ready", int'(attempt_ready), e_ready);
        chk("cyc.cmp_clear",     int'(cmp_clear),     e_clr);
        chk("cyc.resp_valid",    int'(resp_valid),    e_resp);
        chk("cyc.grant",         int'(grant),         e_grant);
        chk("cyc.deny",          int'(deny),          e_deny);
        chk("cyc.locked",        int'(locked),        e_lock);
        chk("cyc.fail_count",    int'(fail_count),    e_fc);
    end

    // ---------------- directed helpers ----------------
    // res_off: edge (1..R) after acceptance carrying the first strobe, 0 = none.
    task automatic attempt(input string tag, input int res_off, input bit rp, input bit dbl,
                           input int exp_grant, input int exp_fc);
        @(negedge clk);
        chk({tag, ".ready"}, int'(attempt_ready), 1);
        attempt_start = 1'b1;
        @(negedge clk);
        attempt_start = 1'b0;
        chk({tag, ".cmp_clear"}, int'(cmp_clear), 1);
        for (int k = 1; k <= R; k++) begin
            result_valid = (k == res_off) || (dbl && k == res_off + 2);
            result_pass  = (k == res_off) ? rp : !rp;
            if (k == R) chk({tag, ".early_resp"}, int'(resp_valid), 0);
            @(negedge clk);
        end
        result_valid = 1'b0;
        result_pass  = 1'b0;
        chk({tag, ".resp_valid"}, int'(resp_valid), 1);
        chk({tag, ".grant"}, int'(grant), exp_grant);
        chk({tag, ".deny"}, int'(deny), 1 - exp_grant);
        @(negedge clk);
        chk({tag, ".resp_drop"}, int'(resp_valid), 0);
        chk({tag, ".fail_count"}, int'(fail_count), exp_fc);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".ready"}, int'(attempt_ready), 1);
        chk({tag, ".outs"}, int'({cmp_clear, resp_valid, grant, deny, locked}), 0);
        chk({tag, ".fail_count"}, int'(fail_count), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  seen;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        attempt("early_pass", 2, 1'b1, 1'b0, 1, 0);
        attempt("late_fail", R, 1'b0, 1'b0, 0, 1);
        attempt("timeout", 0, 1'b0, 1'b0, 0, 2);
        attempt("dbl_strobe", 3, 1'b1, 1'b1, 1, 0);
        attempt("rec1", 4, 1'b0, 1'b0, 0, 1);
        attempt("rec2", 0, 1'b0, 1'b0, 0, 2);
        attempt("rec3", 9, 1'b1, 1'b0, 1, 0);
        chk("rec.locked", int'(locked), 0);

        // Lockout after three consecutive denies.
        attempt("lk1", 0, 1'b0, 1'b0, 0, 1);
        attempt("lk2", 5, 1'b0, 1'b0, 0, 2);
        attempt("lk3", 11, 1'b0, 1'b1, 0, 3);
        chk("lock.locked", int'(locked), 1);
        cnt = 0; seen = 1'b0;
        while (locked && cnt < 2000) begin
            cnt++;
            attempt_start = (cnt <= 20);
            seen = seen | cmp_clear | attempt_ready;
            @(negedge clk);
        end
        attempt_start = 1'b0;
        chk("lock.duration", cnt, L);
        chk("lock.no_accept", int'(seen), 0);
        chk("lock.ready_after", int'(attempt_ready), 1);
        chk("lock.fc_after", int'(fail_count), 0);

        // Reset while waiting at timer=7.
        attempt("pre_rst", 0, 1'b0, 1'b0, 0, 1);
        @(negedge clk);
        attempt_start = 1'b1;
        @(negedge clk);
        attempt_start = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_values("rst_wait");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        chk("rst_wait.no_resp", int'(seen), 0);
        chk("rst_wait.idle", int'(attempt_ready), 1);

        // Reset midway through a lockout.
        attempt("lr1", 0, 1'b0, 1'b0, 0, 1);
        attempt("lr2", 0, 1'b0, 1'b0, 0, 2);
        attempt("lr3", 0, 1'b0, 1'b0, 0, 3);
        repeat (500) @(negedge clk);
        chk("rst_lock.still_locked", int'(locked), 1);
        reset_n = 1'b0;
        #1;
        check_reset_values("rst_lock");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_lock.idle", int'(attempt_ready), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            attempt_start = ($urandom_range(0, 3) == 0);
            result_valid  = ($urandom_range(0, 4) == 0);
            result_pass   = ($urandom_range(0, 3) != 0);
            reset_n       = ($urandom_range(0, 1499) != 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        attempt_start = 1'b0;
        result_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_auth_response_gate
